// File: rtl/udma_spi_arb_pkg.sv
// -----------------------------------------------------------------------------
// udma_spi_arb_pkg
// Shared types for the SPI L2 read arbiter:
//   arb_state_e  - request FSM states (idle / request pending on L2)
//   arb_ch_e     - channel identifier stored in the order FIFO
//   DS_*         - uDMA datasize encodings carried on *_datasize signals
//   arb_rr_pick  - round-robin tie-break between the two channels
// -----------------------------------------------------------------------------
package udma_spi_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_REQ  = 1'b1
    } arb_state_e;

    typedef enum logic {
        CH_CMD = 1'b0,
        CH_TX  = 1'b1
    } arb_ch_e;

    localparam logic [1:0] DS_BYTE = 2'b00;
    localparam logic [1:0] DS_HALF = 2'b01;
    localparam logic [1:0] DS_WORD = 2'b10;

    // On a tie the channel that was not granted last wins.
    function automatic arb_ch_e arb_rr_pick(input logic    cmd_elig,
                                            input logic    tx_elig,
                                            input arb_ch_e last_ch);
        arb_ch_e pick;
        if (cmd_elig && tx_elig) begin
            pick = (last_ch == CH_TX) ? CH_CMD : CH_TX;
        end else if (cmd_elig) begin
            pick = CH_CMD;
        end else begin
            pick = CH_TX;
        end
        return pick;
    endfunction

endpackage

// File: rtl/udma_spi_arb_fifo.sv
// -----------------------------------------------------------------------------
// udma_spi_arb_fifo
// Small synchronous first-word-fall-through FIFO.
// Ports:
//   clk, srst          clock, synchronous active-high reset
//   push_i, data_i     write side; a push while full is dropped
//   pop_i              read side; a pop while empty is ignored
//   data_o             current head (valid whenever empty_o = 0)
//   empty_o, full_o    occupancy flags
// -----------------------------------------------------------------------------
module udma_spi_arb_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Head read is combinational so the consumer sees data the cycle after
    // the write without an extra stage.
    assign data_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/udma_spi_l2_rd_arbiter.sv
// -----------------------------------------------------------------------------
// udma_spi_l2_rd_arbiter
// Shares one uDMA L2 read port between the SPI command stream (cmd) and the
// SPI TX data stream (tx). Reads are issued one grant per cycle at most, the
// granted channel ID is queued in an order FIFO, and returned data (always in
// request order) is steered into a per-channel response buffer that feeds the
// SPI master with valid/ready.
//
// Ports:
//   sys_clk_i, rst_i                  clock, synchronous active-high reset
//   cmd_req/addr/datasize_i, cmd_gnt_o  cmd read request side
//   cmd_data_o, cmd_valid_o, cmd_ready_i cmd response stream
//   tx_*                              same set for TX data
//   l2_req/addr/datasize_o, l2_gnt_i  shared L2 request port
//   l2_rdata_i, l2_rvalid_i           in-order L2 read return
//   busy_o                            reads outstanding or data buffered
//   err_o                             sticky: return with nothing outstanding
//                                     or order-FIFO overflow
//
// Build option: UDMA_SPI_ARB_CMD_PRIO_EN gives cmd fixed priority over tx
// and removes the round-robin pointer.
// -----------------------------------------------------------------------------
module udma_spi_l2_rd_arbiter #(
    parameter int unsigned L2_AWIDTH_NOAL  = 12,
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ORD_DEPTH       = 4
) (
    input  logic                      sys_clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_req_i,
    input  logic [L2_AWIDTH_NOAL-1:0] cmd_addr_i,
    input  logic [1:0]                cmd_datasize_i,
    output logic                      cmd_gnt_o,
    output logic [31:0]               cmd_data_o,
    output logic                      cmd_valid_o,
    input  logic                      cmd_ready_i,
    input  logic                      tx_req_i,
    input  logic [L2_AWIDTH_NOAL-1:0] tx_addr_i,
    input  logic [1:0]                tx_datasize_i,
    output logic                      tx_gnt_o,
    output logic [31:0]               tx_data_o,
    output logic                      tx_valid_o,
    input  logic                      tx_ready_i,
    output logic                      l2_req_o,
    output logic [L2_AWIDTH_NOAL-1:0] l2_addr_o,
    output logic [1:0]                l2_datasize_o,
    input  logic                      l2_gnt_i,
    input  logic [31:0]               l2_rdata_i,
    input  logic                      l2_rvalid_i,
    output logic                      busy_o,
    output logic                      err_o
);

    import udma_spi_arb_pkg::*;

    localparam int unsigned    CRW        = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CRW-1:0] CREDIT_MAX = CRW'(MAX_OUTSTANDING);

    arb_state_e     state_q, state_d;
    arb_ch_e        sel_q, sel_d;
    logic [CRW-1:0] cmd_credit_q, cmd_credit_d;
    logic [CRW-1:0] tx_credit_q, tx_credit_d;
    logic           err_q, err_d;

    logic           cmd_elig, tx_elig;
    logic           cmd_elig_nxt, tx_elig_nxt;
    arb_ch_e        idle_pick, next_pick;
    logic           sel_req;
    logic           grant;
    logic           cmd_pop, tx_pop;

    logic           ord_head, ord_empty, ord_full, ord_pop;
    logic           cmd_push, tx_push;
    logic [31:0]    cmd_head, tx_head;
    logic           cmd_empty, cmd_full, tx_empty, tx_full;

    // ---------------------------------------------------------------- request
    // A credit covers a read from grant until its word leaves the buffer, so
    // a channel can never have more words returning than its buffer holds.
    assign cmd_elig = cmd_req_i && (cmd_credit_q < CREDIT_MAX);
    assign tx_elig  = tx_req_i  && (tx_credit_q  < CREDIT_MAX);

    assign sel_req       = (sel_q == CH_CMD) ? cmd_req_i      : tx_req_i;
    assign l2_addr_o     = (sel_q == CH_CMD) ? cmd_addr_i     : tx_addr_i;
    assign l2_datasize_o = (sel_q == CH_CMD) ? cmd_datasize_i : tx_datasize_i;

    // Request is withdrawn immediately if the selected channel drops its
    // request, and held off while the order FIFO cannot take another ID.
    assign l2_req_o  = (state_q == ARB_REQ) && sel_req && !ord_full;
    assign grant     = l2_req_o && l2_gnt_i;
    assign cmd_gnt_o = grant && (sel_q == CH_CMD);
    assign tx_gnt_o  = grant && (sel_q == CH_TX);

    assign cmd_pop = cmd_valid_o && cmd_ready_i;
    assign tx_pop  = tx_valid_o  && tx_ready_i;

    assign cmd_credit_d = cmd_credit_q + CRW'(cmd_gnt_o) - CRW'(cmd_pop);
    assign tx_credit_d  = tx_credit_q  + CRW'(tx_gnt_o)  - CRW'(tx_pop);

    // Eligibility as it will stand once this cycle's grant/pop land; used to
    // decide whether a back-to-back request can follow a grant.
    assign cmd_elig_nxt = cmd_req_i && (cmd_credit_d < CREDIT_MAX);
    assign tx_elig_nxt  = tx_req_i  && (tx_credit_d  < CREDIT_MAX);

`ifdef UDMA_SPI_ARB_CMD_PRIO_EN
    assign idle_pick = cmd_elig     ? CH_CMD : CH_TX;
    assign next_pick = cmd_elig_nxt ? CH_CMD : CH_TX;
`else
    arb_ch_e last_q;

    assign idle_pick = arb_rr_pick(cmd_elig, tx_elig, last_q);
    // After a grant the just-granted channel becomes "last".
    assign next_pick = arb_rr_pick(cmd_elig_nxt, tx_elig_nxt, sel_q);

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            last_q <= CH_TX;
        end else if (grant) begin
            last_q <= sel_q;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        case (state_q)
            ARB_IDLE: begin
                if (cmd_elig || tx_elig) begin
                    state_d = ARB_REQ;
                    sel_d   = idle_pick;
                end
            end
            ARB_REQ: begin
                if (grant) begin
                    if (cmd_elig_nxt || tx_elig_nxt) begin
                        sel_d = next_pick;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (!sel_req) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // --------------------------------------------------------------- response
    assign ord_pop  = l2_rvalid_i && !ord_empty;
    assign cmd_push = ord_pop && (ord_head == logic'(CH_CMD));
    assign tx_push  = ord_pop && (ord_head == logic'(CH_TX));

    udma_spi_arb_fifo #(
        .WIDTH (1),
        .DEPTH (ORD_DEPTH)
    ) u_ord_fifo (
        .clk     (sys_clk_i),
        .srst    (rst_i),
        .push_i  (grant),
        .data_i  (logic'(sel_q)),
        .pop_i   (ord_pop),
        .data_o  (ord_head),
        .empty_o (ord_empty),
        .full_o  (ord_full)
    );

    udma_spi_arb_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_cmd_buf (
        .clk     (sys_clk_i),
        .srst    (rst_i),
        .push_i  (cmd_push),
        .data_i  (l2_rdata_i),
        .pop_i   (cmd_pop),
        .data_o  (cmd_head),
        .empty_o (cmd_empty),
        .full_o  (cmd_full)
    );

    udma_spi_arb_fifo #(
        .WIDTH (32),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tx_buf (
        .clk     (sys_clk_i),
        .srst    (rst_i),
        .push_i  (tx_push),
        .data_i  (l2_rdata_i),
        .pop_i   (tx_pop),
        .data_o  (tx_head),
        .empty_o (tx_empty),
        .full_o  (tx_full)
    );

    assign cmd_valid_o = !cmd_empty;
    assign tx_valid_o  = !tx_empty;
    // Buffer storage is not reset, so present zero while nothing is valid.
    assign cmd_data_o  = cmd_valid_o ? cmd_head : '0;
    assign tx_data_o   = tx_valid_o  ? tx_head  : '0;

    assign busy_o = !ord_empty || cmd_valid_o || tx_valid_o;

    // Order-FIFO and buffer overflow are unreachable while credits are
    // honoured; they are flagged rather than silently absorbed.
    assign err_d = err_q
                 || (l2_rvalid_i && ord_empty)
                 || (grant && ord_full)
                 || (cmd_push && cmd_full)
                 || (tx_push && tx_full);
    assign err_o = err_q;

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            sel_q        <= CH_CMD;
            cmd_credit_q <= '0;
            tx_credit_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            cmd_credit_q <= cmd_credit_d;
            tx_credit_q  <= tx_credit_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: doc/udma_spi_l2_rd_arbiter.md
Name: udma_spi_l2_rd_arbiter

Overview:
Shares one uDMA L2 read port between the SPI command stream (cmd) and the SPI TX data stream (tx). Arbitrates requests and tracks outstanding reads in an in-order ID FIFO. Routes returned read data to per-channel response buffers, which drive the cmd_i/data_tx_i valid/ready inputs of the SPI master. Sits between the uDMA core TX read path and the SPI master.

Parameters:
L2_AWIDTH_NOAL, 12, L2 word address width.
MAX_OUTSTANDING, 2, read credits per channel; also the depth of each response buffer.
ORD_DEPTH, 4, order-FIFO depth; must be >= 2*MAX_OUTSTANDING.

Ports:
sys_clk_i  in  1  single clock.
rst_i  in  1  synchronous reset, active-high.
cmd_req_i  in  1  cmd channel read request.
cmd_addr_i  in  L2_AWIDTH_NOAL  cmd read address.
cmd_datasize_i  in  2  cmd datasize.
cmd_gnt_o  out  1  cmd request accepted.
cmd_data_o  out  32  cmd read data to SPI master.
cmd_valid_o  out  1  cmd data valid.
cmd_ready_i  in  1  SPI master accepts cmd data.
tx_req_i, tx_addr_i, tx_datasize_i, tx_gnt_o, tx_data_o, tx_valid_o, tx_ready_i  (same as cmd, for TX data).
l2_req_o  out  1  shared port request.
l2_addr_o  out  L2_AWIDTH_NOAL  shared address.
l2_datasize_o  out  2  shared datasize.
l2_gnt_i  in  1  port accepted request.
l2_rdata_i  in  32  read data, returned in request order.
l2_rvalid_i  in  1  read data valid.
busy_o  out  1  any outstanding read or buffered word.
err_o  out  1  sticky: rvalid with empty order FIFO, or order-FIFO overflow.

Behaviour:
- Clock and reset: one clock, sys_clk_i. rst_i is synchronous and active-high.
- Reset values: all gnt/valid/l2_req = 0; data = 0; err_o = 0; busy_o = 0. Credit counters = 0, FIFOs empty, RR pointer = "last = tx" (cmd wins first tie).
- Eligibility: channel eligible iff req_i = 1 and credit_cnt < MAX_OUTSTANDING.
  - credit_cnt increments on gnt_o.
  - credit_cnt decrements on valid_o && ready_i.
  - credit_cnt covers both in-flight reads and buffered words.
- States:
  - IDLE: if any channel is eligible, select by round-robin (the other channel from the last grant wins a tie) and go to REQ. l2_req_o = 0 in IDLE.
  - REQ: l2_req_o = 1; addr/datasize muxed from the selected channel. Selection is locked until l2_gnt_i.
  - On l2_gnt_i: pulse the selected gnt_o the same cycle (combinational), push the channel ID to the order FIFO, update the RR pointer.
  - After a grant: stay in REQ if the other or same channel is eligible after credit update (back-to-back, one grant per cycle max), else IDLE.
  - If the selected requester drops req_i before grant: go to IDLE next cycle, no grant.
- Response path:
  - On l2_rvalid_i, pop the order FIFO head and write l2_rdata_i into that channel's response buffer.
  - No backpressure to L2: credits guarantee buffer space.
  - If rvalid arrives with the order FIFO empty: data dropped, err_o set.
- Outputs: valid_o = buffer non-empty; data_o = buffer head (first-word fall-through, 0-cycle). Minimum latency l2_rvalid_i to valid_o = 1 cycle (registered buffer).
- Simultaneous events: order-FIFO push and pop in the same cycle are legal. A credit increment and decrement on the same channel in the same cycle leave the count unchanged.
- Grant with order FIFO full: grant suppressed (l2_req_o held low). Overflow is unreachable under parameter constraints; it sets err_o if hit.
- Reset mid-operation: all state flushed. Late rvalids arriving after reset set err_o (documented, intended).
- busy_o = (order FIFO non-empty) || (any buffer non-empty).

Optional Feature:
UDMA_SPI_ARB_CMD_PRIO_EN: when defined, cmd has fixed priority over tx whenever eligible; the RR pointer is not implemented. When undefined, round-robin as above.

Decomposition:
- Package udma_spi_arb_pkg:
  - typedef enum {ARB_IDLE, ARB_REQ} arb_state_e;
  - typedef enum logic {CH_CMD=0, CH_TX=1} arb_ch_e;
  - datasize encoding constants.
- Sub-module udma_spi_arb_fifo: parameterised sync FIFO (width, depth, FWFT, full/empty).
  - Instanced for the order FIFO (width 1) and two response buffers (width 32).

Test Plan:
- Single cmd read, addr 0x010, l2_gnt_i immediate, rvalid 2 cycles later with 0xA5A5_0001 -> cmd_gnt_o 1 pulse, cmd_valid_o next cycle with 0xA5A5_0001, busy_o drops after ready.
- Both req held continuously, gnt always 1 -> grants alternate cmd, tx, cmd, tx; with UDMA_SPI_ARB_CMD_PRIO_EN -> cmd only until credits exhausted (2), then tx.
- tx_ready_i = 0, tx_req_i held -> exactly 2 tx grants, then tx excluded. Raise ready -> one new grant after each pop.
- Interleaved returns cmd,tx,cmd with data 0x1,0x2,0x3 -> cmd_data_o sees 0x1 then 0x3, tx_data_o sees 0x2, order preserved.
- l2_gnt_i held 0 for 5 cycles while cmd selected, tx_req_i rises -> l2_addr_o stays cmd address, no switch until grant.
- rvalid with nothing outstanding, and rst_i asserted with 2 reads in flight -> err_o = 1; after reset, all outputs 0 and credits 0.
